mod12_count_checker: RTL and testbench

Synthesizable protocol checker on the reader end of the mod-12 loadable up/down counter interface. It passively samples the counter's control inputs (dut_reset, load, mode, data_in) and its data_out. It runs a cycle-accurate reference model of the counter, compares every predicted value against the observed output, and reports mismatches and running statistics. It is used in emulation and in-system self-test, next to the counter.

---
 rtl/mod12_count_checker.sv | 83 ++++++++
 tb/tb_mod12_count_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod12_count_checker.sv
// rtl/mod12_count_checker.sv - passive reference-model checker for a mod-12 loadable up/down counter
// Optional build macro COUNT_CHK_RESYNC_EN: on a mismatch with data_out <= 11 the model adopts data_out.
module mod12_count_checker #(
  parameter int ERR_W = 8,
  parameter int CHK_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dut_reset,
  input  logic             load,
  input  logic             mode,
  input  logic [3:0]       data_in,
  input  logic [3:0]       data_out,
  output logic [3:0]       expected,
  output logic             exp_valid,
  output logic             mismatch,
  output logic             bad_load,
  output logic             fail,
  output logic [ERR_W-1:0] err_count,
  output logic [CHK_W-1:0] chk_count
);

  typedef enum logic {
    UNSYNC = 1'b0,
    TRACK  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] model_nxt;
  logic [3:0] base;
  logic       cmp_miss;
  logic       load_bad;

  always_comb begin
    cmp_miss  = (state == TRACK) && (data_out != expected);
    load_bad  = load && !dut_reset && (data_in > 4'd11);
    base      = expected;
`ifdef COUNT_CHK_RESYNC_EN
    // An out-of-range observation is never adopted; the model carries on.
    if (cmp_miss && (data_out <= 4'd11)) base = data_out;
`endif
    state_nxt = state;
    model_nxt = expected;
    if (dut_reset) begin
      state_nxt = TRACK;
      model_nxt = 4'd0;
    end else if (load) begin
      if (load_bad) begin
        state_nxt = UNSYNC;
      end else begin
        state_nxt = TRACK;
        model_nxt = data_in;
      end
    end else if (state == TRACK) begin
      if (mode) model_nxt = (base == 4'd11) ? 4'd0 : base + 4'd1;
      else      model_nxt = (base == 4'd0) ? 4'd11 : base - 4'd1;
    end
  end

  assign exp_valid = (state == TRACK);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= UNSYNC;
      expected  <= 4'd0;
      mismatch  <= 1'b0;
      bad_load  <= 1'b0;
      fail      <= 1'b0;
      err_count <= '0;
      chk_count <= '0;
    end else begin
      state    <= state_nxt;
      expected <= model_nxt;
      mismatch <= cmp_miss;
      bad_load <= load_bad;
      if (cmp_miss || load_bad) fail <= 1'b1;
      if ((state == TRACK) && (chk_count != {CHK_W{1'b1}})) chk_count <= chk_count + 1'b1;
      if (cmp_miss && (err_count != {ERR_W{1'b1}})) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mod12_count_checker.sv
// tb/tb_mod12_count_checker.sv - directed bench with a cycle model for mod12_count_checker
module tb_mod12_count_checker;
  localparam int ERR_W = 8;
  localparam int CHK_W = 16;

  logic             clock = 1'b0;
  logic             reset, dut_reset, load, mode;
  logic [3:0]       data_in, data_out;
  logic [3:0]       expected;
  logic             exp_valid, mismatch, bad_load, fail;
  logic [ERR_W-1:0] err_count;
  logic [CHK_W-1:0] chk_count;

  int n_pass = 0;
  int n_total = 0;
  bit started = 0;

  // bench-side counter that produces data_out; glitch overwrites its state, inj overrides its output
  int   ctr = 0;
  bit   glitch = 0;
  int   glitch_val = 0;
  bit   inj = 0;
  logic [3:0] inj_val = 4'd0;

  mod12_count_checker #(.ERR_W(ERR_W), .CHK_W(CHK_W)) dut (
    .clock(clock), .reset(reset), .dut_reset(dut_reset), .load(load), .mode(mode),
    .data_in(data_in), .data_out(data_out), .expected(expected), .exp_valid(exp_valid),
    .mismatch(mismatch), .bad_load(bad_load), .fail(fail),
    .err_count(err_count), .chk_count(chk_count)
  );

  always #5 clock = ~clock;

  assign data_out = inj ? inj_val : 4'(ctr);

  always @(posedge clock) begin
    if (glitch)         ctr <= glitch_val;
    else if (dut_reset) ctr <= 0;
    else if (load)      ctr <= int'(data_in);
    else                ctr <= mode ? (ctr + 1) % 12 : (ctr + 11) % 12;
  end

  function automatic int step_val(int v, bit up);
    return up ? (v + 1) % 12 : (v + 11) % 12;
  endfunction

  function automatic int sat_inc(int c, int w);
    return (c == (1 << w) - 1) ? c : c + 1;
  endfunction

  function automatic int adopt(int pred, int seen);
`ifdef COUNT_CHK_RESYNC_EN
    if (seen != pred && seen < 12) return seen;
`endif
    return pred;
  endfunction

  // reference model
  bit m_track, m_mis, m_bad, m_fail;
  int m_val, m_err, m_chk;

  always @(posedge clock) begin
    if (!reset) begin
      m_track <= 0; m_val <= 0; m_mis <= 0; m_bad <= 0; m_fail <= 0; m_err <= 0; m_chk <= 0;
    end else begin
      m_mis <= m_track && (int'(data_out) != m_val);
      m_bad <= load && !dut_reset && (data_in > 11);
      if ((m_track && int'(data_out) != m_val) || (load && !dut_reset && data_in > 11)) m_fail <= 1;
      if (m_track) m_chk <= sat_inc(m_chk, CHK_W);
      if (m_track && int'(data_out) != m_val) m_err <= sat_inc(m_err, ERR_W);
      if (dut_reset) begin
        m_track <= 1; m_val <= 0;
      end else if (load) begin
        m_track <= (data_in < 12);
        if (data_in < 12) m_val <= int'(data_in);
      end else if (m_track) begin
        m_val <= step_val(adopt(m_val, int'(data_out)), mode);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    if (started) begin
      check("model_exp_valid", 32'(exp_valid), 32'(m_track));
      if (m_track) check("model_expected", 32'(expected), 32'(m_val));
      check("model_mismatch", 32'(mismatch), 32'(m_mis));
      check("model_bad_load", 32'(bad_load), 32'(m_bad));
      check("model_fail", 32'(fail), 32'(m_fail));
      check("model_err_count", 32'(err_count), 32'(m_err));
      check("model_chk_count", 32'(chk_count), 32'(m_chk));
    end
  end

  task automatic drive(input bit dr, input bit ld, input bit md, input logic [3:0] din);
    dut_reset = dr; load = ld; mode = md; data_in = din;
    @(posedge clock);
    #1;
  endtask

  int up_seq[14]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0, 1, 2};
  int down_seq[7] = '{4, 3, 2, 1, 0, 11, 10};

  initial begin
    reset = 1'b0; dut_reset = 1'b0; load = 1'b0; mode = 1'b0; data_in = 4'd0;
    drive(0, 0, 0, 4'd0);
    started = 1;
    check("reset_expected", 32'(expected), 32'd0);
    check("reset_exp_valid", 32'(exp_valid), 32'd0);
    check("reset_fail", 32'(fail), 32'd0);
    reset = 1'b1;

    // count up across the wrap
    drive(1, 0, 0, 4'd0);
    check("sync_expected", 32'(expected), 32'd0);
    check("sync_exp_valid", 32'(exp_valid), 32'd1);
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, 1, 4'd0);
      check("up_seq", 32'(expected), 32'(up_seq[i]));
    end

    // load 5 and count down across the wrap
    drive(0, 1, 0, 4'd5);
    check("up_chk_count", 32'(chk_count), 32'd15);
    check("load5_expected", 32'(expected), 32'd5);
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 4'd0);
      check("down_seq", 32'(expected), 32'(down_seq[i]));
    end
    check("down_err_count", 32'(err_count), 32'd0);
    check("down_fail", 32'(fail), 32'd0);
    check("down_mismatch", 32'(mismatch), 32'd0);

    // illegal load value
    drive(0, 1, 0, 4'd13);
    check("bad_load_pulse", 32'(bad_load), 32'd1);
    check("bad_load_fail", 32'(fail), 32'd1);
    check("bad_load_unsync", 32'(exp_valid), 32'd0);
    check("bad_load_err", 32'(err_count), 32'd0);
    drive(0, 0, 0, 4'd0);
    check("bad_load_clear", 32'(bad_load), 32'd0);
    check("bad_load_still_unsync", 32'(exp_valid), 32'd0);

    // dut_reset beats an illegal load in the same cycle
    drive(1, 1, 0, 4'd13);
    check("rst_load_bad_load", 32'(bad_load), 32'd0);
    check("rst_load_valid", 32'(exp_valid), 32'd1);
    check("rst_load_expected", 32'(expected), 32'd0);
    drive(0, 1, 1, 4'd11);
    check("load11_up", 32'(expected), 32'd11);
    drive(0, 0, 1, 4'd0);
    check("wrap_after_load11", 32'(expected), 32'd0);

    // counter jumps to 7 while the model is at 4
    glitch = 1; glitch_val = 7;
    drive(0, 1, 1, 4'd4);
    glitch = 0;
    check("glitch_expected", 32'(expected), 32'd4);
    drive(0, 0, 1, 4'd0);
    check("glitch_mismatch", 32'(mismatch), 32'd1);
    check("glitch_err1", 32'(err_count), 32'd1);
`ifdef COUNT_CHK_RESYNC_EN
    check("glitch_next_expected", 32'(expected), 32'd8);
`else
    check("glitch_next_expected", 32'(expected), 32'd5);
`endif
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 4'd0);
`ifdef COUNT_CHK_RESYNC_EN
    check("glitch_err_later", 32'(err_count), 32'd1);
`else
    check("glitch_err_later", 32'(err_count), 32'd4);
`endif

    // out-of-range data_out every cycle saturates err_count
    inj = 1; inj_val = 4'd15;
    for (int i = 0; i < 300; i++) drive(0, 0, 1, 4'd0);
    check("err_saturated", 32'(err_count), 32'd255);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 4'd0);
    check("err_stays_saturated", 32'(err_count), 32'd255);
    check("sat_mismatch", 32'(mismatch), 32'd1);
    check("pre_reset_fail", 32'(fail), 32'd1);
    check("pre_reset_track", 32'(exp_valid), 32'd1);
    inj = 0;

    // checker reset while failed and tracking
    reset = 1'b0;
    drive(0, 0, 1, 4'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_chk", 32'(chk_count), 32'd0);
    check("rst_valid", 32'(exp_valid), 32'd0);
    check("rst_expected", 32'(expected), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 4'd0);
    check("post_rst_unsync", 32'(exp_valid), 32'd0);
    check("post_rst_no_chk", 32'(chk_count), 32'd0);
    drive(0, 1, 0, 4'd3);
    check("resync_load", 32'(expected), 32'd3);
    drive(0, 0, 0, 4'd0);
    check("resync_down", 32'(expected), 32'd2);
    check("resync_chk", 32'(chk_count), 32'd1);

    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

endmodule
